// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter for the UFM Avalon-MM data read port.
// One read in flight at a time, followed by an enforced idle gap; stalled responses time out with rerr.
module flash_read_arbiter #(
    parameter int ADDR_WIDTH     = 17,
    parameter int DATA_WIDTH     = 32,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_read,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ack,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_rvalid,
    output logic                  req0_rerr,
    input  logic                  req1_read,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ack,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_rvalid,
    output logic                  req1_rerr,
    output logic                  flash_read,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic                  flash_waitrequest,
    input  logic [DATA_WIDTH-1:0] flash_readdata,
    input  logic                  flash_readdatavalid,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_GAP       = 3'd3
    } state_t;

    // Terminal counts: the counters start at 0, so the last cycle is N-1.
    localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                        state_reg, state_next;
    logic                          grant_reg, grant_next;
    logic                          last_grant_reg, last_grant_next;
    logic                          grant_pick;
    logic [3:0]                    gap_cnt_reg, gap_cnt_next;
    logic [7:0]                    to_cnt_reg, to_cnt_next;
    logic                          flash_read_reg, flash_read_next;
    logic [ADDR_WIDTH-1:0]         flash_addr_reg, flash_addr_next;
    logic [1:0]                    ack_reg, ack_next;
    logic [1:0]                    rvalid_reg, rvalid_next;
    logic [1:0]                    rerr_reg, rerr_next;
    logic [1:0][DATA_WIDTH-1:0]    rdata_reg, rdata_next;
    logic                          busy_reg, busy_next;
    logic [1:0]                    req_vec;

    assign req_vec = {req1_read, req0_read};

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        grant_pick      = 1'b0;
        gap_cnt_next    = gap_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        flash_read_next = flash_read_reg;
        flash_addr_next = flash_addr_reg;
        ack_next        = '0;
        rvalid_next     = '0;
        rerr_next       = '0;
        rdata_next      = rdata_reg;

        case (state_reg)
            S_IDLE: begin
                flash_read_next = 1'b0;
                if (|req_vec) begin
                    // Under contention the port that did not win last time gets the flash.
                    if (req_vec == 2'b11) begin
                        grant_pick = ~last_grant_reg;
                    end else begin
                        grant_pick = req_vec[1];
                    end
                    grant_next      = grant_pick;
                    last_grant_next = grant_pick;
                    flash_addr_next = grant_pick ? req1_addr : req0_addr;
                    flash_read_next = 1'b1;
                    state_next      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!flash_waitrequest) begin
                    flash_read_next     = 1'b0;
                    ack_next[grant_reg] = 1'b1;
                    to_cnt_next         = '0;
                    state_next          = S_WAIT_DATA;
                end
            end

            S_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    rdata_next[grant_reg]  = flash_readdata;
                    rvalid_next[grant_reg] = 1'b1;
                    gap_cnt_next           = '0;
                    state_next             = S_GAP;
                end else if (to_cnt_reg >= TIMEOUT_LAST) begin
                    rdata_next[grant_reg]  = '0;
                    rvalid_next[grant_reg] = 1'b1;
                    rerr_next[grant_reg]   = 1'b1;
                    gap_cnt_next           = '0;
                    state_next             = S_GAP;
                end else if (to_cnt_reg != 8'hFF) begin
                    to_cnt_next = to_cnt_reg + 8'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt_reg >= GAP_LAST) begin
                    state_next = S_IDLE;
                end else if (gap_cnt_reg != 4'hF) begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end

            default: begin
                flash_read_next = 1'b0;
                state_next      = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            gap_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            flash_read_reg <= 1'b0;
            flash_addr_reg <= '0;
            ack_reg        <= '0;
            rvalid_reg     <= '0;
            rerr_reg       <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            gap_cnt_reg    <= gap_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            flash_read_reg <= flash_read_next;
            flash_addr_reg <= flash_addr_next;
            ack_reg        <= ack_next;
            rvalid_reg     <= rvalid_next;
            rerr_reg       <= rerr_next;
            busy_reg       <= busy_next;
        end
    end

    // Per-port read data holds its last value until that port's next response.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg[gi] <= '0;
                end else begin
                    rdata_reg[gi] <= rdata_next[gi];
                end
            end
        end
    endgenerate

    assign req0_ack    = ack_reg[0];
    assign req0_rvalid = rvalid_reg[0];
    assign req0_rerr   = rerr_reg[0];
    assign req0_rdata  = rdata_reg[0];
    assign req1_ack    = ack_reg[1];
    assign req1_rvalid = rvalid_reg[1];
    assign req1_rerr   = rerr_reg[1];
    assign req1_rdata  = rdata_reg[1];
    assign flash_read  = flash_read_reg;
    assign flash_addr  = flash_addr_reg;
    assign busy        = busy_reg;

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the single Avalon-MM data read port of the on-chip flash (UFM) between two requesters. Port 0 is the code-memory power-on loader; port 1 is the CPU/OCD flash reader. Round-robin arbitration, one outstanding read at a time, minimum idle gap between reads, and a response timeout. Response data is routed back to the granted requester unchanged; byte ordering stays with the requester.

Parameters:
ADDR_WIDTH, 17, flash word address width
DATA_WIDTH, 32, flash data width
GAP_CYCLES, 4, idle cycles forced after each completed read (1..15)
TIMEOUT_CYCLES, 255, max cycles waiting for readdatavalid after acceptance (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
req0_read  in  1  port 0 read request, held until req0_ack
req0_addr  in  ADDR_WIDTH  port 0 word address, stable while req0_read
req0_ack  out  1  pulse: port 0 request accepted by flash
req0_rdata  out  DATA_WIDTH  port 0 read data
req0_rvalid  out  1  pulse: req0_rdata/req0_rerr valid
req0_rerr  out  1  qualifies req0_rvalid: timeout, data is 0
req1_read, req1_addr, req1_ack, req1_rdata, req1_rvalid, req1_rerr  same as port 0, for port 1
flash_read  out  1  Avalon read
flash_addr  out  ADDR_WIDTH  Avalon address
flash_waitrequest  in  1  Avalon waitrequest
flash_readdata  in  DATA_WIDTH  Avalon readdata
flash_readdatavalid  in  1  Avalon readdatavalid
busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, state S_IDLE, last_grant=1 (port 0 wins first), gap/timeout counters 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - S_IDLE:
    - If any reqN_read is high, grant and go to S_ISSUE.
    - Single request: grant that port.
    - Both requesting: grant the port opposite last_grant, then update last_grant.
    - Latch grant and address. flash_read=1 and flash_addr=latched address from the next cycle.
  - S_ISSUE:
    - flash_read held high and flash_addr held stable until flash_waitrequest=0.
    - In that cycle: reqN_ack pulses 1 cycle later for the granted port, flash_read drops next cycle, timeout counter clears, go to S_WAIT_DATA.
  - S_WAIT_DATA:
    - On flash_readdatavalid: capture flash_readdata into granted reqN_rdata, pulse reqN_rvalid with rerr=0 next cycle, go to S_GAP.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES: rdata=0, rvalid=1, rerr=1, go to S_GAP.
    - readdatavalid and timeout in the same cycle: data wins, rerr=0.
  - S_GAP:
    - Counts GAP_CYCLES cycles, then S_IDLE. No request is granted during the gap.
  - Any illegal state encoding goes to S_IDLE.
- flash_readdatavalid outside S_WAIT_DATA is ignored: no rvalid, no data capture. This covers late responses after a timeout or after a mid-operation reset.
- Non-granted port: ack/rvalid/rerr stay 0, and its rdata holds its previous value.
- A requester dropping reqN_read before ack is a protocol violation; the arbiter still completes the latched read and returns the response.
- Latency, zero waitrequest, readdatavalid 2 cycles after acceptance:
  - req seen at cycle T, flash_read at T+1, ack at T+2, rvalid at T+4.
  - Next grant no earlier than rvalid cycle + GAP_CYCLES.
- Counters: gap 4-bit, timeout 8-bit, both saturating. Neither counter wraps.

Test Plan:
- Single port 0 read, addr=0x00010, waitrequest=0, readdatavalid 2 cycles later with 0xDEADBEEF -> flash_addr=0x00010; req0_ack 1 pulse; req0_rvalid 1 pulse with rdata=0xDEADBEEF, rerr=0; port 1 outputs stay 0.
- Both ports request continuously from reset, addr0=0x1, addr1=0x2 -> flash_addr sequence 0x1,0x2,0x1,0x2; grants alternate; at least GAP_CYCLES=4 idle cycles between flash_read pulses.
- waitrequest held high 5 cycles on a port 1 read -> flash_read and flash_addr stable for 6 cycles; req1_ack only after waitrequest falls; exactly one accepted read.
- No readdatavalid after acceptance, TIMEOUT_CYCLES=8 -> req_rvalid with rerr=1, rdata=0 on the 8th waiting cycle. A readdatavalid with 0x12345678 injected 3 cycles later -> ignored, no rvalid.
- readdatavalid coincides with the timeout expiry cycle, data 0xCAFEF00D -> rvalid, rerr=0, rdata=0xCAFEF00D.
- Reset asserted in S_WAIT_DATA, then released; a stray readdatavalid arrives 1 cycle after release -> all outputs 0 during reset; stray data dropped; the next port 0 request is granted first.
